// File: rtl/divider_alu_if.sv
// Handshake and operand bus of the divider unit.
// master drives en/op/start/A/B; slave returns Dquot/Drem/busy/done/div_by_zero.
interface divider_alu_if #(
  parameter int W = 3
);
  logic           en;
  logic [1:0]     op;
  logic           start;
  logic [2*W-1:0] A;
  logic [W-1:0]   B;
  logic [2*W-1:0] Dquot;
  logic [W-1:0]   Drem;
  logic           busy;
  logic           done;
  logic           div_by_zero;

  modport master (
    output en, op, start, A, B,
    input  Dquot, Drem, busy, done, div_by_zero
  );

  modport slave (
    input  en, op, start, A, B,
    output Dquot, Drem, busy, done, div_by_zero
  );
endinterface

// File: rtl/divider_alu.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor.
// Ports: clk, rst (sync, active high), bus (divider_alu_if.slave).
// Optional macro DIV_EARLY_EXIT_EN: A < B finishes on the accepting edge.
module divider_alu #(
  parameter int         W      = 3,
  parameter logic [1:0] OP_DIV = 2'b10
) (
  input  logic          clk,
  input  logic          rst,
  divider_alu_if.slave  bus
);

  localparam int CW = $clog2(2*W+1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  // s_q holds the unconsumed dividend bits on the left and the
  // quotient bits collected so far on the right.
  logic [2*W-1:0] s_q;
  logic [2*W-1:0] quot_q;
  // The partial remainder is always below B, so its top bit is
  // never set and only W bits are kept.
  logic [W-1:0]   p_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   rem_q;
  logic [CW-1:0]  cnt_q;
  logic           dz_q;

  logic           accept;
  logic           zero;
  logic           early;
  logic           last;
  logic [W:0]     t;
  logic           ge;
  logic [W-1:0]   p_nx;
  logic [2*W-1:0] s_nx;

  assign accept = bus.en & bus.start
                & (bus.op == OP_DIV)
                & (state_q == IDLE);
  assign zero = (bus.B == '0);

`ifdef DIV_EARLY_EXIT_EN
  assign early = (bus.A < {{W{1'b0}}, bus.B});
`else
  assign early = 1'b0;
`endif

  assign last = (cnt_q == CW'(1));
  assign t    = {p_q, s_q[2*W-1]};
  assign ge   = (t >= {1'b0, b_q});
  assign p_nx = ge ? W'(t - {1'b0, b_q})
                   : t[W-1:0];
  assign s_nx = {s_q[2*W-2:0], ge};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = (zero || early) ? DONE : RUN;
      end
      RUN: begin
        if (bus.en && last)
          state_d = DONE;
      end
      DONE: begin
        if (bus.en)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      p_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else if (bus.en) begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            b_q <= bus.B;
            if (zero) begin
              quot_q <= '1;
              rem_q  <= '1;
              dz_q   <= 1'b1;
            end else if (early) begin
              quot_q <= '0;
              rem_q  <= bus.A[W-1:0];
              dz_q   <= 1'b0;
            end else begin
              s_q   <= bus.A;
              p_q   <= '0;
              cnt_q <= CW'(2*W);
            end
          end
        end
        RUN: begin
          s_q   <= s_nx;
          p_q   <= p_nx;
          cnt_q <= cnt_q - CW'(1);
          if (last) begin
            quot_q <= s_nx;
            rem_q  <= p_nx;
            dz_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Dquot       = quot_q;
  assign bus.Drem        = rem_q;
  assign bus.div_by_zero = dz_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);

endmodule

// File: tb/tb_divider_alu.sv
// Self-checking bench for divider_alu (W=3) against a plain
// arithmetic reference model.
module tb_divider_alu;

  localparam int         W      = 3;
  localparam logic [1:0] OP_DIV = 2'b10;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   last_q;
  int   last_r;

  divider_alu_if #(.W(W)) bus ();

  divider_alu #(.W(W), .OP_DIV(OP_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: quotient/remainder from plain division, latency in
  // enabled edges from the accepting edge to the done cycle.
  function automatic void model(
    input  int a,
    input  int b,
    output int q,
    output int r,
    output int dz,
    output int lat
  );
    if (b == 0) begin
      q = 63; r = 7; dz = 1; lat = 1;
    end else begin
      q = a / b; r = a % b; dz = 0; lat = 2*W + 1;
`ifdef DIV_EARLY_EXIT_EN
      if (a < b) lat = 1;
`endif
    end
  endfunction

  // Stimulus only: issues one request from a negedge and returns at
  // the negedge where done is seen (or when the budget runs out).
  task automatic issue(
    input  logic [2*W-1:0] a,
    input  logic [W-1:0]   b,
    output int             edges
  );
    bus.en = 1'b1; bus.op = OP_DIV;
    bus.A = a; bus.B = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = 6'($urandom);
    bus.B = 3'($urandom);
    edges = 1;
    while (bus.done !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.op = 2'b00; bus.start = 1'b0;
    bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.Dquot, bus.Drem, bus.busy, bus.done,
         bus.div_by_zero} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs got q=%0d r=%0d busy=%b done=%b dz=%b want all 0",
               bus.Dquot, bus.Drem, bus.busy, bus.done, bus.div_by_zero);
    end
    last_q = 0; last_r = 0;
  endtask

  task automatic test_basic();
    int a_t [3] = '{42, 63, 63};
    int b_t [3] = '{5, 7, 1};
    int q, r, dz, lat, e;
    for (int i = 0; i < 3; i++) begin
      model(a_t[i], b_t[i], q, r, dz, lat);
      bus.en = 1'b1; bus.op = OP_DIV;
      bus.A = 6'(a_t[i]); bus.B = 3'(b_t[i]);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_busy_rise got %b want 1", bus.busy);
      end
      e = 1;
      while (bus.done !== 1'b1 && e < 40) begin
        @(negedge clk);
        e++;
      end
      n_checks++;
      if (e != lat) begin
        n_fail++;
        $display("FAIL basic_latency %0d/%0d got %0d want %0d",
                 a_t[i], b_t[i], e, lat);
      end
      n_checks++;
      if (bus.Dquot !== q[5:0] || bus.Drem !== r[2:0] ||
          bus.div_by_zero !== dz[0] || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_result %0d/%0d got q=%0d r=%0d dz=%b busy=%b want q=%0d r=%0d dz=%0d busy=1",
                 a_t[i], b_t[i], bus.Dquot, bus.Drem,
                 bus.div_by_zero, bus.busy, q, r, dz);
      end
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_busy_drop got busy=%b done=%b want 0 0",
                 bus.busy, bus.done);
      end
      last_q = q; last_r = r;
    end
  endtask

  task automatic test_div_zero();
    int q, r, dz, lat, e;
    model(10, 0, q, r, dz, lat);
    issue(6'd10, 3'd0, e);
    n_checks++;
    if (e != lat || bus.Dquot !== q[5:0] || bus.Drem !== r[2:0] ||
        bus.div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL div_zero got lat=%0d q=%0d r=%0d dz=%b want lat=%0d q=%0d r=%0d dz=1",
               e, bus.Dquot, bus.Drem, bus.div_by_zero, lat, q, r);
    end
    @(negedge clk);
    model(6, 3, q, r, dz, lat);
    issue(6'd6, 3'd3, e);
    n_checks++;
    if (e != lat || bus.Dquot !== q[5:0] || bus.Drem !== r[2:0] ||
        bus.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL div_zero_clear got lat=%0d q=%0d r=%0d dz=%b want lat=%0d q=%0d r=%0d dz=0",
               e, bus.Dquot, bus.Drem, bus.div_by_zero, lat, q, r);
    end
    @(negedge clk);
    last_q = q; last_r = r;
  endtask

  task automatic test_small();
    int q, r, dz, lat, e;
    model(2, 3, q, r, dz, lat);
    issue(6'd2, 3'd3, e);
    n_checks++;
    if (e != lat || bus.Dquot !== q[5:0] || bus.Drem !== r[2:0] ||
        bus.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL small_a_lt_b got lat=%0d q=%0d r=%0d dz=%b want lat=%0d q=%0d r=%0d",
               e, bus.Dquot, bus.Drem, bus.div_by_zero, lat, q, r);
    end
    @(negedge clk);
    last_q = q; last_r = r;
  endtask

  task automatic test_enable_freeze();
    int e;
    bus.en = 1'b1; bus.op = OP_DIV;
    bus.A = 6'd42; bus.B = 3'd5; bus.start = 1'b1;
    @(negedge clk); e = 1;
    bus.start = 1'b0;
    @(negedge clk); e++;
    @(negedge clk); e++;
    bus.en = 1'b0;
    bus.start = 1'b1;
    repeat (3) begin
      @(negedge clk); e++;
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 ||
          bus.Dquot !== last_q[5:0] || bus.Drem !== last_r[2:0]) begin
        n_fail++;
        $display("FAIL freeze_outputs got busy=%b done=%b q=%0d r=%0d want 1 0 q=%0d r=%0d",
                 bus.busy, bus.done, bus.Dquot, bus.Drem, last_q, last_r);
      end
    end
    bus.start = 1'b0;
    bus.en = 1'b1;
    while (bus.done !== 1'b1 && e < 40) begin
      @(negedge clk);
      e++;
    end
    n_checks++;
    if (e != 10 || bus.Dquot !== 6'd8 || bus.Drem !== 3'd2) begin
      n_fail++;
      $display("FAIL freeze_result got edges=%0d q=%0d r=%0d want 10 8 2",
               e, bus.Dquot, bus.Drem);
    end
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL freeze_done_hold got done=%b busy=%b want 1 1",
               bus.done, bus.busy);
    end
    bus.en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_done_release got done=%b busy=%b want 0 0",
               bus.done, bus.busy);
    end
    last_q = 8; last_r = 2;
  endtask

  task automatic test_bad_op();
    bus.en = 1'b1; bus.op = 2'b11;
    bus.A = 6'd42; bus.B = 3'd5; bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    bus.op = OP_DIV;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_op_ignored got busy=%b done=%b want 0 0",
               bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    bus.en = 1'b1; bus.op = OP_DIV;
    bus.A = 6'd42; bus.B = 3'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({bus.Dquot, bus.Drem, bus.busy, bus.done,
         bus.div_by_zero} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid got q=%0d r=%0d busy=%b done=%b dz=%b want all 0",
               bus.Dquot, bus.Drem, bus.busy, bus.done, bus.div_by_zero);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle got busy=%b want 0", bus.busy);
    end
    issue(6'd6, 3'd3, e);
    n_checks++;
    if (e != 7 || bus.Dquot !== 6'd2 || bus.Drem !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid_recover got edges=%0d q=%0d r=%0d want 7 2 0",
               e, bus.Dquot, bus.Drem);
    end
    @(negedge clk);
    last_q = 2; last_r = 0;
  endtask

  task automatic test_start_while_busy();
    int e;
    bus.en = 1'b1; bus.op = OP_DIV;
    bus.A = 6'd42; bus.B = 3'd5; bus.start = 1'b1;
    @(negedge clk); e = 1;
    bus.start = 1'b0;
    @(negedge clk); e++;
    bus.A = 6'd9; bus.B = 3'd2; bus.start = 1'b1;
    @(negedge clk); e++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && e < 40) begin
      @(negedge clk);
      e++;
    end
    n_checks++;
    if (e != 7 || bus.Dquot !== 6'd8 || bus.Drem !== 3'd2) begin
      n_fail++;
      $display("FAIL busy_start_ignored got edges=%0d q=%0d r=%0d want 7 8 2",
               e, bus.Dquot, bus.Drem);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.Dquot !== 6'd8) begin
      n_fail++;
      $display("FAIL busy_start_not_queued got busy=%b q=%0d want 0 8",
               bus.busy, bus.Dquot);
    end
    last_q = 8; last_r = 2;
  endtask

  task automatic test_back_to_back();
    int e1, e2;
    bus.en = 1'b1; bus.op = OP_DIV;
    bus.A = 6'd42; bus.B = 3'd5; bus.start = 1'b1;
    @(negedge clk); e1 = 1;
    while (bus.done !== 1'b1 && e1 < 40) begin
      @(negedge clk);
      e1++;
    end
    @(negedge clk); e2 = 1;
    while (bus.done !== 1'b1 && e2 < 40) begin
      @(negedge clk);
      e2++;
    end
    bus.start = 1'b0;
    n_checks++;
    if (e1 != 7 || e2 != 2*W + 2 || bus.Dquot !== 6'd8) begin
      n_fail++;
      $display("FAIL back_to_back got first=%0d period=%0d q=%0d want 7 8 8",
               e1, e2, bus.Dquot);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_stop got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_random();
    int a, b, q, r, dz, lat, e;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 63));
      b = (i % 8 == 0) ? 0 : int'($urandom_range(0, 7));
      model(a, b, q, r, dz, lat);
      issue(6'(a), 3'(b), e);
      n_checks++;
      if (e != lat || bus.Dquot !== q[5:0] || bus.Drem !== r[2:0] ||
          bus.div_by_zero !== dz[0]) begin
        n_fail++;
        $display("FAIL random %0d/%0d got lat=%0d q=%0d r=%0d dz=%b want lat=%0d q=%0d r=%0d dz=%0d",
                 a, b, e, bus.Dquot, bus.Drem, bus.div_by_zero,
                 lat, q, r, dz);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    test_reset();
    test_basic();
    test_div_zero();
    test_small();
    test_enable_freeze();
    test_bad_op();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_alu.md
Name: divider_alu

Overview:
- Sequential unsigned restoring divider for the ALU datapath. It is the inverse operation of the multiplier unit.
- Takes a 2W-bit dividend (the multiplier's product width) and a W-bit divisor.
- Produces a 2W-bit quotient and a W-bit remainder, one quotient bit per enabled cycle.
- Sits beside the multiplier behind the same op/en decode. It adds a start/busy/done handshake because the result is multi-cycle.

Parameters:
- W, 3, divisor and remainder width; dividend and quotient are 2*W bits
- OP_DIV, 2'b10, op encoding that selects this unit; start is ignored for any other op

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- en  input  1  unit enable; low freezes all internal state and outputs
- op  input  2  ALU operation select; operation accepted only when op == OP_DIV
- start  input  1  request; sampled only in IDLE with en=1 and op==OP_DIV
- A  input  2W  dividend, captured on the accepting edge
- B  input  W  divisor, captured on the accepting edge
- Dquot  output  2W  registered quotient, holds until the next completion
- Drem  output  W  registered remainder, holds until the next completion
- busy  output  1  high from the accepting edge until DONE is left
- done  output  1  one-cycle pulse, result valid
- div_by_zero  output  1  registered flag qualifying the current Dquot/Drem

Behaviour:
- Reset (rst=1 at a rising edge, any state, including mid-division):
  - state=IDLE; Dquot=0, Drem=0, busy=0, done=0, div_by_zero=0.
  - Internal dividend shift register, partial remainder and counter are cleared.
  - Reset has priority over en.
- en=0: no state, counter or output changes. A done pulse already high stays high until the next enabled edge. start is ignored.
- States: IDLE, RUN, DONE.
- IDLE:
  - start&en&(op==OP_DIV) at an edge → capture A, B.
  - If B==0 → DONE: Dquot={2W{1}}, Drem={W{1}}, div_by_zero=1.
  - Otherwise → RUN: count=2W, partial remainder P=0 (W+1 bits), shift reg S=A.
  - busy=1 from this edge.
- RUN, on each enabled edge:
  - T={P[W-1:0],S[2W-1]}; S shifts left by 1.
  - If T>=B: P=T-B and shift in quotient bit 1. Else P=T and shift in 0.
  - count decrements.
  - On the edge where count reaches 0 → DONE: Dquot = the quotient shift bits, Drem=P[W-1:0], div_by_zero=0.
- DONE: done=1 and busy=1 for exactly one enabled cycle, then → IDLE with busy=0, done=0.
- Latency:
  - Nonzero divisor: done high in the cycle after the (2W+1)th enabled edge counted from the accepting edge. W=3 gives 7 edges.
  - Divide-by-zero: done high after 1 edge.
- start while busy (RUN or DONE) is ignored and not queued.
- A/B changes after the accepting edge do not affect the result.
- start in the DONE cycle is ignored. Back-to-back throughput is one operation per 2W+2 cycles.
- Invariant on completion: A == Dquot*B + Drem, with Drem < B (B≠0).
- All arithmetic is unsigned.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined:
  - In IDLE with B≠0 and A<B, the accepting edge goes straight to DONE with Dquot=0, Drem=A[W-1:0], div_by_zero=0.
  - Latency matches divide-by-zero (1 edge).
  - The A≥B path is unchanged.
- Undefined: A<B takes the full RUN path (2W+1 edges) and gives the same numeric result.

Test Plan:
- A=42, B=5, start 1 cycle → busy rises next cycle; done after 7 edges with Dquot=8, Drem=2, div_by_zero=0.
- A=63, B=7 → Dquot=9, Drem=0. Follow with A=63, B=1 → Dquot=63, Drem=0. Check busy drops the cycle after done.
- A=10, B=0 → done after 1 edge, Dquot=63, Drem=7, div_by_zero=1. Next division (A=6, B=3 → 2 r0) clears div_by_zero.
- A=2, B=3 → Dquot=0, Drem=2. Done after 7 edges without DIV_EARLY_EXIT_EN, after 1 edge with it.
- A=42, B=5 with en=0 for 3 cycles mid-RUN → outputs frozen, done after 10 edges total, result 8 r2. Apply start with op=2'b11 → ignored, busy stays 0.
- Start A=42, B=5; pulse rst at RUN edge 3 → all outputs 0, state IDLE. Also pulse start mid-RUN with A=9, B=2 in a separate run → ignored, the first result completes unchanged.
